// File: rtl/regfile_pkg.sv
// Shared register-file constants, write-request type and address decoder.
package regfile_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NREGS  = 32;

  // r0 is hardwired to zero; writes to it are dropped.
  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // Binary register address to one-hot enable vector.
  function automatic logic [NREGS-1:0] onehot_dec(input logic [ADDR_W-1:0] addr);
    logic [NREGS-1:0] vec;
    vec       = '0;
    vec[addr] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/wb_fwd_lookup.sv
// Forwarding search over the pending write-back entries for one read port.
// Walks the ring from oldest (head) to newest; a later match overrides an
// earlier one, so the newest pending write for the address wins.
module wb_fwd_lookup
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  wb_req_t                    entries_i [DEPTH],
  input  logic [DEPTH-1:0]           valid_i,
  input  logic [$clog2(DEPTH)-1:0]   head_i,
  input  logic [ADDR_W-1:0]          rd_addr_i,
  output logic                       hit_o,
  output logic [DATA_W-1:0]          data_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW-1:0] idx;

  // Oldest-to-newest scan; last match is the newest.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head_i + PtrW'(k);
      if (valid_i[idx] && (rd_addr_i != ZERO_REG) && (entries_i[idx].addr == rd_addr_i)) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-back request queue feeding the register file enable/data inputs.
// Buffers (addr, data) requests, retires one per cycle as a one-hot enable
// plus shared data bus, and forwards pending writes to two read ports.
module regfile_wb_queue
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [ADDR_W-1:0]        in_addr_i,
  input  logic [DATA_W-1:0]        in_data_i,
  input  logic                     hold_i,
  output logic [NREGS-1:0]         wr_en_o,
  output logic [DATA_W-1:0]        wr_data_o,
  input  logic [ADDR_W-1:0]        rd_addr_a_i,
  output logic                     fwd_hit_a_o,
  output logic [DATA_W-1:0]        fwd_data_a_o,
  input  logic [ADDR_W-1:0]        rd_addr_b_i,
  output logic                     fwd_hit_b_o,
  output logic [DATA_W-1:0]        fwd_data_b_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  wb_req_t          mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push, pop;
  wb_req_t          head;

  assign head       = mem_q[rd_ptr_q];
  // Ready depends only on registered count; a same-cycle pop never frees a slot.
  assign in_ready_o = (count_q != CntW'(DEPTH));
  // Writes to r0 complete the handshake but are never stored.
  assign push       = in_valid_i && in_ready_o && (in_addr_i != ZERO_REG);
  assign pop        = (count_q != '0) && !hold_i;
  assign count_o    = count_q;

  // Next-state for pointers, count and per-entry valid bits.
  always_comb begin
    valid_d  = valid_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PtrW'(1);
    end
    if (push) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PtrW'(1);
    end
    count_d = count_q + CntW'(push) - CntW'(pop);
  end

  // Control state, cleared asynchronously so pending writes are discarded.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      valid_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry payload storage; no reset needed since valid bits gate every use.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q].addr <= in_addr_i;
      mem_q[wr_ptr_q].data <= in_data_i;
    end
  end

  // Retire port: regfile captures at the same edge the head is popped.
  always_comb begin
    wr_en_o   = '0;
    wr_data_o = '0;
    if (pop) begin
      wr_en_o   = onehot_dec(head.addr);
      wr_data_o = head.data;
    end
  end

  wb_fwd_lookup #(
    .DEPTH (DEPTH)
  ) u_fwd_a (
    .entries_i (mem_q),
    .valid_i   (valid_q),
    .head_i    (rd_ptr_q),
    .rd_addr_i (rd_addr_a_i),
    .hit_o     (fwd_hit_a_o),
    .data_o    (fwd_data_a_o)
  );

  wb_fwd_lookup #(
    .DEPTH (DEPTH)
  ) u_fwd_b (
    .entries_i (mem_q),
    .valid_i   (valid_q),
    .head_i    (rd_ptr_q),
    .rd_addr_i (rd_addr_b_i),
    .hit_o     (fwd_hit_b_o),
    .data_o    (fwd_data_b_o)
  );

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue with a write-back scoreboard and a
// behavioural register file driven from the DUT enable/data outputs.
module tb_regfile_wb_queue;

  logic        clk;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        hold;
  logic [31:0] wr_en;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr_a;
  logic        fwd_hit_a;
  logic [31:0] fwd_data_a;
  logic [4:0]  rd_addr_b;
  logic        fwd_hit_b;
  logic [31:0] fwd_data_b;
  logic [2:0]  count;

  typedef struct {
    logic [31:0] en;
    logic [31:0] data;
  } exp_t;

  exp_t        sb [$];
  exp_t        mon_e;
  int          total = 0;
  int          bad   = 0;
  logic [31:0] rf [32] = '{default: '0};
  logic        acc;

  regfile_wb_queue #(
    .DEPTH (4)
  ) dut (
    .clk          (clk),
    .clr          (clr),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_addr_i    (in_addr),
    .in_data_i    (in_data),
    .hold_i       (hold),
    .wr_en_o      (wr_en),
    .wr_data_o    (wr_data),
    .rd_addr_a_i  (rd_addr_a),
    .fwd_hit_a_o  (fwd_hit_a),
    .fwd_data_a_o (fwd_data_a),
    .rd_addr_b_i  (rd_addr_b),
    .fwd_hit_b_o  (fwd_hit_b),
    .fwd_data_b_o (fwd_data_b),
    .count_o      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request for one cycle; record it in the scoreboard if it was taken.
  task automatic push(input logic [4:0] a, input logic [31:0] d, output logic taken);
    exp_t e;
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    @(negedge clk);
    taken = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (taken && (a != 5'd0)) begin
      e.en   = 32'h1 << a;
      e.data = d;
      sb.push_back(e);
    end
  endtask

  // Behavioural register file array.
  always @(posedge clk) begin
    for (int i = 0; i < 32; i++) begin
      if (wr_en[i]) rf[i] <= wr_data;
    end
  end

  // Scoreboard: every retired write must match the oldest expected one.
  always @(negedge clk) begin
    if (wr_en !== 32'h0) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_write", {32'h0, wr_en}, 64'h0);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_wr_en", {32'h0, wr_en}, {32'h0, mon_e.en});
        chk("sb_wr_data", {32'h0, wr_data}, {32'h0, mon_e.data});
      end
    end
  end

  initial begin
    clr       = 1'b1;
    in_valid  = 1'b0;
    in_addr   = '0;
    in_data   = '0;
    hold      = 1'b0;
    rd_addr_a = '0;
    rd_addr_b = '0;
    acc       = 1'b0;

    // Reset state.
    tick();
    tick();
    clr = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_fwd_hit_a", fwd_hit_a, 0);
    chk("rst_fwd_data_a", fwd_data_a, 0);
    chk("rst_fwd_hit_b", fwd_hit_b, 0);

    // Single write into an empty queue: retires in the following cycle.
    push(5'd7, 32'hDEADBEEF, acc);
    chk("single_wr_en", wr_en, 32'h0000_0080);
    chk("single_wr_data", wr_data, 32'hDEADBEEF);
    chk("single_count", count, 1);
    tick();
    chk("single_count_after", count, 0);
    chk("single_wr_en_after", wr_en, 0);
    chk("single_rf7", rf[7], 32'hDEADBEEF);

    // Fill while held, then release while offering a fifth request.
    hold = 1'b1;
    for (int i = 1; i <= 4; i++) push(5'(i), 32'h100 + i, acc);
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    chk("full_hold_wr_en", wr_en, 0);
    hold     = 1'b0;
    in_valid = 1'b1;
    in_addr  = 5'd9;
    in_data  = 32'hBAD0_0009;
    #1;
    chk("full_pop_in_ready", in_ready, 0);
    chk("walk_wr_en_0", wr_en, 32'h2);
    tick();
    in_valid = 1'b0;
    chk("full_count_after_pop", count, 3);
    chk("walk_wr_en_1", wr_en, 32'h4);
    tick();
    chk("walk_wr_en_2", wr_en, 32'h8);
    tick();
    chk("walk_wr_en_3", wr_en, 32'h10);
    tick();
    chk("walk_count_end", count, 0);
    chk("walk_wr_en_end", wr_en, 0);

    // Forwarding: newest pending write for an address wins.
    hold = 1'b1;
    push(5'd5, 32'h11, acc);
    push(5'd5, 32'h22, acc);
    rd_addr_a = 5'd5;
    rd_addr_b = 5'd6;
    #1;
    chk("fwd_hit_a", fwd_hit_a, 1);
    chk("fwd_data_a", fwd_data_a, 32'h22);
    chk("fwd_miss_hit_b", fwd_hit_b, 0);
    chk("fwd_miss_data_b", fwd_data_b, 0);
    rd_addr_b = 5'd5;
    #1;
    chk("fwd_data_b", fwd_data_b, 32'h22);
    hold = 1'b0;
    #1;
    chk("fwd_retire_data_a", fwd_data_a, 32'h22);
    chk("fwd_retire_wr_data", wr_data, 32'h11);
    tick();
    chk("fwd_last_hit_a", fwd_hit_a, 1);
    chk("fwd_last_data_a", fwd_data_a, 32'h22);
    tick();
    chk("fwd_empty_hit_a", fwd_hit_a, 0);
    chk("fwd_empty_data_a", fwd_data_a, 0);
    rd_addr_a = 5'd6;
    push(5'd6, 32'h33, acc);
    chk("fwd_head_hit_a", fwd_hit_a, 1);
    chk("fwd_head_data_a", fwd_data_a, 32'h33);
    tick();

    // Zero register: handshake completes, nothing is queued or forwarded.
    rd_addr_a = 5'd0;
    push(5'd0, 32'hFFFF_FFFF, acc);
    chk("zero_accepted", acc, 1);
    chk("zero_count", count, 0);
    chk("zero_wr_en", wr_en, 0);
    chk("zero_fwd_hit_a", fwd_hit_a, 0);

    // Back-to-back stream through the wrapping pointers.
    for (int i = 0; i < 10; i++) begin
      push(5'(i + 1), 32'(i), acc);
      chk("stream_count", count, 1);
    end
    tick();
    chk("stream_count_end", count, 0);
    for (int i = 0; i < 10; i++) chk("stream_rf", rf[i + 1], 32'(i));

    // Asynchronous clear with pending writes: all of them are dropped.
    hold = 1'b1;
    push(5'd20, 32'hA20, acc);
    push(5'd21, 32'hA21, acc);
    push(5'd22, 32'hA22, acc);
    rd_addr_a = 5'd21;
    #1;
    chk("clr_pre_hit_a", fwd_hit_a, 1);
    chk("clr_pre_count", count, 3);
    #2;
    hold = 1'b0;
    clr  = 1'b1;
    #1;
    chk("clr_count", count, 0);
    chk("clr_wr_en", wr_en, 0);
    chk("clr_fwd_hit_a", fwd_hit_a, 0);
    chk("clr_in_ready", in_ready, 1);
    sb.delete();
    tick();
    clr = 1'b0;
    tick();
    tick();
    chk("clr_rf20", rf[20], 0);
    chk("clr_rf21", rf[21], 0);
    chk("clr_rf22", rf[22], 0);
    chk("clr_count_after", count, 0);
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
